// File: rtl/rst_seq_ctl_if.sv
// Bundle between the staged reset sequencer and the sub-blocks it brings up.
// The master side supplies lock and per-stage done; the slave side is the sequencer.
interface rst_seq_ctl_if #(
    parameter int STAGES = 4
);
    logic              clk_locked;
    logic [STAGES-1:0] stage_done;
    logic [STAGES-1:0] stage_rst;
    logic              all_ready;
    logic              fault;
    logic [1:0]        retry_cnt;
    logic [2:0]        seq_state;

    modport master (
        output clk_locked, stage_done,
        input  stage_rst, all_ready, fault, retry_cnt, seq_state
    );

    modport slave (
        input  clk_locked, stage_done,
        output stage_rst, all_ready, fault, retry_cnt, seq_state
    );
endinterface

// File: rtl/rst_seq_ctl.sv
// Staged reset-release sequencer: releases sub-block resets one at a time after lock,
// retries the whole sequence on a stage timeout and latches a fault after repeated failures.
module rst_seq_ctl #(
    parameter int          STAGES    = 4,
    parameter logic [15:0] STAGE_DLY = 16'h0100,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF,
    parameter logic [1:0]  MAX_RETRY = 2'd3
) (
    input logic          clk,
    input logic          rst,
    rst_seq_ctl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_WAIT  = 3'd2,
        S_READY = 3'd3,
        S_RETRY = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        k, k_nxt;
    logic [15:0]       dly_cnt, dly_nxt;
    logic [15:0]       to_cnt, to_nxt;
    logic [STAGES-1:0] stage_rst_q, stage_rst_nxt;
    logic              all_ready_q, all_ready_nxt;
    logic              fault_q, fault_nxt;
    logic [1:0]        retry_q, retry_nxt;
    logic              lock_meta, locked_s;
    logic              done_k, lock_lost;
    logic [1:0]        retry_inc;

    // Lock synchroniser: clk_locked comes from the PLL, unrelated to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= bus.clk_locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= 3'd0;
            dly_cnt     <= 16'd0;
            to_cnt      <= 16'd0;
            stage_rst_q <= '1;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 2'd0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            dly_cnt     <= dly_nxt;
            to_cnt      <= to_nxt;
            stage_rst_q <= stage_rst_nxt;
            all_ready_q <= all_ready_nxt;
            fault_q     <= fault_nxt;
            retry_q     <= retry_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        dly_nxt       = dly_cnt;
        to_nxt        = to_cnt;
        stage_rst_nxt = stage_rst_q;
        all_ready_nxt = all_ready_q;
        fault_nxt     = fault_q;
        retry_nxt     = retry_q;

        done_k = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (k == 3'(i)) done_k = bus.stage_done[i];
        end
        retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
        lock_lost = !locked_s && (state == S_DELAY || state == S_WAIT || state == S_READY);

        if (lock_lost) begin
            // Lock loss restarts bring-up without counting as a retry
            state_nxt     = S_IDLE;
            stage_rst_nxt = '1;
            all_ready_nxt = 1'b0;
            k_nxt         = 3'd0;
            dly_nxt       = 16'd0;
            to_nxt        = 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    stage_rst_nxt = '1;
                    all_ready_nxt = 1'b0;
                    k_nxt         = 3'd0;
                    dly_nxt       = 16'd0;
                    to_nxt        = 16'd0;
                    if (locked_s) state_nxt = S_DELAY;
                end
                S_DELAY: begin
                    if (dly_cnt == STAGE_DLY - 16'd1) begin
                        for (int i = 0; i < STAGES; i++) begin
                            if (k == 3'(i)) stage_rst_nxt[i] = 1'b0;
                        end
                        to_nxt    = 16'd0;
                        state_nxt = S_WAIT;
                    end else begin
                        dly_nxt = dly_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    // Done is checked before timeout so a same-cycle collision advances
                    if (done_k) begin
                        if (k == 3'(STAGES - 1)) begin
                            all_ready_nxt = 1'b1;
                            state_nxt     = S_READY;
                        end else begin
                            k_nxt     = k + 3'd1;
                            dly_nxt   = 16'd0;
                            state_nxt = S_DELAY;
                        end
                    end else if (to_cnt == TIMEOUT - 16'd1) begin
                        state_nxt = S_RETRY;
                    end else begin
                        to_nxt = to_cnt + 16'd1;
                    end
                end
                S_READY: begin
                    if (!(&bus.stage_done)) begin
                        all_ready_nxt = 1'b0;
                        state_nxt     = S_RETRY;
                    end
                end
                S_RETRY: begin
                    stage_rst_nxt = '1;
                    all_ready_nxt = 1'b0;
                    retry_nxt     = retry_inc;
                    k_nxt         = 3'd0;
                    dly_nxt       = 16'd0;
                    to_nxt        = 16'd0;
                    if (retry_inc == MAX_RETRY) begin
                        fault_nxt = 1'b1;
                        state_nxt = S_FAULT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_FAULT: begin
                    stage_rst_nxt = '1;
                    all_ready_nxt = 1'b0;
                    fault_nxt     = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.stage_rst = stage_rst_q;
    assign bus.all_ready = all_ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.seq_state = state;
endmodule

// File: tb/tb_rst_seq_ctl.sv
// Directed bench for rst_seq_ctl: table-driven nominal bring-up plus hand-written
// sequences for timeout, fault, lock loss, done/timeout collision and async reset.
module tb_rst_seq_ctl;
    localparam logic [2:0] IDLE = 3'd0, DELAY = 3'd1, WAIT = 3'd2,
                           READY = 3'd3, RETRY = 3'd4, FAULT = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rst_seq_ctl_if #(.STAGES(4)) bus ();

    rst_seq_ctl #(
        .STAGES   (4),
        .STAGE_DLY(16'd8),
        .TIMEOUT  (16'd32),
        .MAX_RETRY(2'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         cycles;
        logic       lock;
        logic [3:0] done;
        logic [10:0] exp;
    } vec_t;

    vec_t vec[20];

    function automatic logic [10:0] pk(input logic [3:0] r, input logic rd, input logic f,
                                       input logic [1:0] rc, input logic [2:0] s);
        return {r, rd, f, rc, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {bus.stage_rst, bus.all_ready, bus.fault, bus.retry_cnt, bus.seq_state};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rst=%h rdy=%b flt=%b rc=%0d st=%0d, want rst=%h rdy=%b flt=%b rc=%0d st=%0d",
                     name, act[10:7], act[6], act[5], act[4:3], act[2:0],
                     exp[10:7], exp[6], exp[5], exp[4:3], exp[2:0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.clk_locked = 1'b0;
        bus.stage_done = 4'h0;
        ticks(2);
        rst = 1'b0;
    endtask

    // Entered just after the DELAY-entry edge for stage k; leaves just after done[k] is taken
    task automatic release_stage(input int k, input logic [3:0] done_prev, input logic [1:0] rc);
        logic [3:0] held, freed;
        held  = 4'hF << k;
        freed = 4'hF << (k + 1);
        ticks(7);
        check($sformatf("stg%0d_delay", k), pk(held, 1'b0, 1'b0, rc, DELAY));
        tick();
        check($sformatf("stg%0d_release", k), pk(freed, 1'b0, 1'b0, rc, WAIT));
        ticks(2);
        check($sformatf("stg%0d_wait", k), pk(freed, 1'b0, 1'b0, rc, WAIT));
        bus.stage_done = done_prev | (4'b0001 << k);
        tick();
        if (k == 3) check("stg3_ready", pk(4'h0, 1'b1, 1'b0, rc, READY));
        else        check($sformatf("stg%0d_next", k), pk(freed, 1'b0, 1'b0, rc, DELAY));
    endtask

    initial begin
        vec[0]  = '{2, 1'b0, 4'h0, pk(4'hF, 0, 0, 0, IDLE)};
        vec[1]  = '{2, 1'b1, 4'h0, pk(4'hF, 0, 0, 0, IDLE)};
        vec[2]  = '{1, 1'b1, 4'h0, pk(4'hF, 0, 0, 0, DELAY)};
        vec[3]  = '{7, 1'b1, 4'h0, pk(4'hF, 0, 0, 0, DELAY)};
        vec[4]  = '{1, 1'b1, 4'h0, pk(4'hE, 0, 0, 0, WAIT)};
        vec[5]  = '{2, 1'b1, 4'h0, pk(4'hE, 0, 0, 0, WAIT)};
        vec[6]  = '{1, 1'b1, 4'h1, pk(4'hE, 0, 0, 0, DELAY)};
        vec[7]  = '{7, 1'b1, 4'h1, pk(4'hE, 0, 0, 0, DELAY)};
        vec[8]  = '{1, 1'b1, 4'h1, pk(4'hC, 0, 0, 0, WAIT)};
        vec[9]  = '{2, 1'b1, 4'h1, pk(4'hC, 0, 0, 0, WAIT)};
        vec[10] = '{1, 1'b1, 4'h3, pk(4'hC, 0, 0, 0, DELAY)};
        vec[11] = '{7, 1'b1, 4'h3, pk(4'hC, 0, 0, 0, DELAY)};
        vec[12] = '{1, 1'b1, 4'h3, pk(4'h8, 0, 0, 0, WAIT)};
        vec[13] = '{2, 1'b1, 4'h3, pk(4'h8, 0, 0, 0, WAIT)};
        vec[14] = '{1, 1'b1, 4'h7, pk(4'h8, 0, 0, 0, DELAY)};
        vec[15] = '{7, 1'b1, 4'h7, pk(4'h8, 0, 0, 0, DELAY)};
        vec[16] = '{1, 1'b1, 4'h7, pk(4'h0, 0, 0, 0, WAIT)};
        vec[17] = '{2, 1'b1, 4'h7, pk(4'h0, 0, 0, 0, WAIT)};
        vec[18] = '{1, 1'b1, 4'hF, pk(4'h0, 1, 0, 0, READY)};
        vec[19] = '{5, 1'b1, 4'hF, pk(4'h0, 1, 0, 0, READY)};

        bus.clk_locked = 1'b0;
        bus.stage_done = 4'h0;
        ticks(2);
        check("reset_state", pk(4'hF, 0, 0, 0, IDLE));

        // Nominal bring-up
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.clk_locked = vec[i].lock;
            bus.stage_done = vec[i].done;
            ticks(vec[i].cycles);
            check($sformatf("nominal[%0d]", i), vec[i].exp);
        end

        // Single timeout on stage 2, clean second attempt, then READY drop leads to FAULT
        do_reset();
        bus.clk_locked = 1'b1;
        ticks(3);
        check("to_delay0", pk(4'hF, 0, 0, 0, DELAY));
        release_stage(0, 4'h0, 2'd0);
        release_stage(1, 4'h1, 2'd0);
        ticks(8);
        check("to_wait2", pk(4'h8, 0, 0, 0, WAIT));
        ticks(31);
        check("to_wait2_last", pk(4'h8, 0, 0, 0, WAIT));
        tick();
        check("to_retry", pk(4'h8, 0, 0, 0, RETRY));
        tick();
        check("to_idle", pk(4'hF, 0, 0, 1, IDLE));
        bus.stage_done = 4'h0;
        tick();
        check("to_redelay", pk(4'hF, 0, 0, 1, DELAY));
        release_stage(0, 4'h0, 2'd1);
        release_stage(1, 4'h1, 2'd1);
        release_stage(2, 4'h3, 2'd1);
        release_stage(3, 4'h7, 2'd1);
        bus.stage_done = 4'hD;
        tick();
        check("ready_drop_retry", pk(4'h0, 0, 0, 1, RETRY));
        tick();
        check("ready_drop_fault", pk(4'hF, 0, 1, 2, FAULT));
        #3 rst = 1'b1;
        #1 check("async_from_fault", pk(4'hF, 0, 0, 0, IDLE));
        tick();
        rst = 1'b0;

        // Stage 1 never reports done: two timeouts end in FAULT
        do_reset();
        bus.clk_locked = 1'b1;
        ticks(3);
        release_stage(0, 4'h0, 2'd0);
        ticks(8);
        check("flt_wait1", pk(4'hC, 0, 0, 0, WAIT));
        ticks(32);
        check("flt_retry1", pk(4'hC, 0, 0, 0, RETRY));
        tick();
        check("flt_idle1", pk(4'hF, 0, 0, 1, IDLE));
        tick();
        check("flt_delay0b", pk(4'hF, 0, 0, 1, DELAY));
        ticks(8);
        check("flt_wait0b", pk(4'hE, 0, 0, 1, WAIT));
        tick();
        check("flt_delay1b", pk(4'hE, 0, 0, 1, DELAY));
        ticks(8);
        check("flt_wait1b", pk(4'hC, 0, 0, 1, WAIT));
        ticks(32);
        check("flt_retry2", pk(4'hC, 0, 0, 1, RETRY));
        tick();
        check("flt_fault", pk(4'hF, 0, 1, 2, FAULT));
        bus.stage_done = 4'hF;
        ticks(4);
        check("flt_done_ignored", pk(4'hF, 0, 1, 2, FAULT));
        bus.stage_done = 4'h0;
        bus.clk_locked = 1'b0;
        ticks(5);
        check("flt_lockloss_ignored", pk(4'hF, 0, 1, 2, FAULT));

        // Lock loss while waiting on stage 2
        do_reset();
        bus.clk_locked = 1'b1;
        ticks(3);
        release_stage(0, 4'h0, 2'd0);
        release_stage(1, 4'h1, 2'd0);
        ticks(8);
        check("ll_wait2", pk(4'h8, 0, 0, 0, WAIT));
        bus.clk_locked = 1'b0;
        ticks(2);
        check("ll_still_wait", pk(4'h8, 0, 0, 0, WAIT));
        tick();
        check("ll_idle", pk(4'hF, 0, 0, 0, IDLE));
        bus.clk_locked = 1'b1;
        bus.stage_done = 4'h0;
        ticks(2);
        check("ll_relock_idle", pk(4'hF, 0, 0, 0, IDLE));
        tick();
        check("ll_relock_delay", pk(4'hF, 0, 0, 0, DELAY));
        release_stage(0, 4'h0, 2'd0);

        // Done arrives on the final WAIT cycle before timeout
        do_reset();
        bus.clk_locked = 1'b1;
        ticks(3);
        ticks(8);
        check("col_wait0", pk(4'hE, 0, 0, 0, WAIT));
        ticks(31);
        check("col_wait0_last", pk(4'hE, 0, 0, 0, WAIT));
        bus.stage_done = 4'h1;
        tick();
        check("col_done_wins", pk(4'hE, 0, 0, 0, DELAY));
        ticks(8);
        check("col_stage1", pk(4'hC, 0, 0, 0, WAIT));

        // Async reset between edges during DELAY of stage 3, after one retry
        do_reset();
        bus.clk_locked = 1'b1;
        ticks(3);
        ticks(8);
        ticks(32);
        check("ar_retry", pk(4'hE, 0, 0, 0, RETRY));
        tick();
        tick();
        check("ar_redelay", pk(4'hF, 0, 0, 1, DELAY));
        release_stage(0, 4'h0, 2'd1);
        release_stage(1, 4'h1, 2'd1);
        release_stage(2, 4'h3, 2'd1);
        ticks(3);
        check("ar_delay3", pk(4'h8, 0, 0, 1, DELAY));
        #3 rst = 1'b1;
        #1 check("ar_async", pk(4'hF, 0, 0, 0, IDLE));
        tick();
        rst = 1'b0;
        tick();
        check("ar_after", pk(4'hF, 0, 0, 0, IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
